fifo_wr_ctrl: RTL and testbench
===============================

# fifo_wr_ctrl

Write-domain controller for the asynchronous FIFO. It accepts write requests in the `clk_w` domain and advances the binary/Gray write pointer. It produces the RAM write address and enable. Full status comes from comparing the next write pointer with the Gray read pointer `r_ptr_s`, which the two-stage synchronizer has already brought into `clk_w`. It sits between the write-side client and the FIFO storage/synchronizer pair, and is the only writer of `w_ptr`.

## Interface
- `POINTER_WIDTH`, 4, address bits; FIFO depth = 2^POINTER_WIDTH; pointers are POINTER_WIDTH+1 bits
- `AFULL_THRESH`, 14, almost-full level (valid only with `WR_LEVEL_EN`); range 1..2^POINTER_WIDTH
- `clk_w`  input  1  write clock
- `rst_n`  input  1  reset, asynchronous assert, active-low
- `w_en`  input  1  client write request, one entry per cycle
- `w_ovf_clr`  input  1  clears sticky overflow
- `r_ptr_s`  input  POINTER_WIDTH+1  Gray read pointer, already synchronized to `clk_w`
- `w_ptr`  output  POINTER_WIDTH+1  registered Gray write pointer, to read-domain synchronizer
- `waddr`  output  POINTER_WIDTH  RAM write address
- `wr_mem`  output  1  RAM write strobe, = `w_en & ~w_full`
- `w_full`  output  1  registered full flag
- `w_ovf`  output  1  sticky overflow: write attempted while full
- `w_level`  output  POINTER_WIDTH+1  occupancy seen from write side (`WR_LEVEL_EN` only)
- `w_afull`  output  1  `w_level >= AFULL_THRESH` (`WR_LEVEL_EN` only)

## Operation
- Reset: `w_ptr`=0, internal binary pointer `wbin`=0, `waddr`=0, `w_full`=0, `w_ovf`=0, `w_level`=0, `w_afull`=0.
- Accept: `wr_mem = w_en & ~w_full`. On accept, `wbin_next = wbin + 1`, modulo 2^(POINTER_WIDTH+1). Otherwise `wbin_next = wbin`.
- `wgray_next = wbin_next ^ (wbin_next >> 1)`. `w_ptr` and `wbin` both register their next values.
- `waddr = wbin[POINTER_WIDTH-1:0]`. It is combinational from the register and always points to the slot being written this cycle.
- Full: `w_full` registers the result of `wgray_next == {~r_ptr_s[PW:PW-1], r_ptr_s[PW-2:0]}`.
- Overflow: `w_en & w_full` sets `w_ovf`. `w_ovf_clr` clears it. When both occur in the same cycle, set wins. Rejected writes do not move any pointer.
- Wrap-around: the MSB toggles every 2^POINTER_WIDTH accepts. Gray ordering guarantees one bit change per increment.
- No state machine beyond pointer/flag registers. There are no client-side stalls other than `w_full`.

## Timing
- `w_ptr` changes exactly one cycle after an accepted `w_en`, and by exactly one Gray bit.
- `w_full` asserts in the cycle after the write that fills the last slot. A back-to-back write in that cycle is rejected.
- `w_full` deasserts one `clk_w` after `r_ptr_s` shows the read. This is pessimistic by the synchronizer's 2-cycle latency, by design.
- `r_ptr_s` changing in the same cycle as an accept: the compare uses the new `wgray_next` and current `r_ptr_s`. Both are registered into `w_full` together.
- `rst_n` low mid-operation: all outputs return to reset values immediately. The read domain must also be reset; the client must not rely on partially written data.

## Configuration
- `WR_LEVEL_EN` defined, level logic compiled in:
  - Gray-to-binary conversion of `r_ptr_s`.
  - `w_level = wbin_next - rbin`, registered, range 0..2^POINTER_WIDTH.
  - `w_afull` registered from `w_level_next >= AFULL_THRESH`.
- `WR_LEVEL_EN` undefined: `w_level` and `w_afull` are tied 0, and no conversion logic exists.

## Structure
- Shared package `async_fifo_pkg`:
  - `POINTER_WIDTH` default.
  - Pointer typedef `ptr_t` (POINTER_WIDTH+1 bits).
  - `bin2gray` / `gray2bin` functions. The read-side controller reuses these.
- One sub-module: `gray_to_bin`, an XOR prefix chain. It is instantiated only under `WR_LEVEL_EN`.

## Test plan
- Reset, with `r_ptr_s`=0 and `w_en`=0 → `w_ptr`=5'b00000, `waddr`=0, `w_full`=0, `w_ovf`=0.
- 16 consecutive writes, `r_ptr_s`=0 → `waddr` sequence 0..15. After the 16th write, `w_ptr`=5'b11000 and `w_full`=1 on the next cycle.
- 17th write while full → `wr_mem`=0, `w_ptr` unchanged, `w_ovf`=1. Pulse `w_ovf_clr` → `w_ovf`=0.
- While full, drive `r_ptr_s`=5'b00001 → `w_full`=0 one cycle later. One more write → `w_ptr`=Gray(17)=5'b11001 and `w_full`=1 again.
- Wrap: 32 writes interleaved with `r_ptr_s` tracking reads → `w_ptr` returns to 5'b00000 with `w_full`=0. Check one bit changes per increment throughout.
- `WR_LEVEL_EN`, 14 writes with `r_ptr_s`=0 → `w_level`=14 and `w_afull`=1. Then `r_ptr_s`=Gray(3)=5'b00010 → `w_level`=11 and `w_afull`=0.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
// Shared definitions for the asynchronous FIFO write and read controllers:
//   DEF_POINTER_WIDTH : default address width (FIFO depth = 2**DEF_POINTER_WIDTH)
//   ptr_t             : pointer type, one extra MSB for the wrap/lap bit
//   bin2gray/gray2bin : pointer code conversions, shared with the read side
// -----------------------------------------------------------------------------
package async_fifo_pkg;

   localparam int DEF_POINTER_WIDTH = 4;

   typedef logic [DEF_POINTER_WIDTH:0] ptr_t;

   function automatic ptr_t bin2gray(input ptr_t bin);
      return bin ^ (bin >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at and above it.
   function automatic ptr_t gray2bin(input ptr_t gray);
      ptr_t bin;
      bin[DEF_POINTER_WIDTH] = gray[DEF_POINTER_WIDTH];
      for (int i = DEF_POINTER_WIDTH - 1; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray_to_bin.sv
// -----------------------------------------------------------------------------
// gray_to_bin
// Combinational Gray-to-binary converter built as an XOR prefix chain.
// Ports:
//   gray : input  [W-1:0]  Gray-coded value
//   bin  : output [W-1:0]  binary equivalent
// -----------------------------------------------------------------------------
module gray_to_bin import async_fifo_pkg::*; #(
   parameter int W = DEF_POINTER_WIDTH + 1
) (
   input  logic [W-1:0] gray,
   output logic [W-1:0] bin
);

   // Each output bit is the reduction XOR of the Gray bits from the MSB down
   // to its own position; written per bit so no bit feeds back on the vector.
   for (genvar i = 0; i < W; i++) begin : g_bit
      assign bin[i] = ^gray[W-1:i];
   end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
// Write-domain controller of the asynchronous FIFO. Accepts client writes,
// advances the binary/Gray write pointer, drives the RAM write port and
// derives the full flag from the synchronized Gray read pointer.
//
// Optional feature macro: WR_LEVEL_EN
//   defined   -> occupancy level (w_level) and almost-full (w_afull) logic
//   undefined -> w_level and w_afull tied to 0, no Gray conversion logic
//
// Ports:
//   clk_w      : in  write clock
//   rst_n      : in  asynchronous active-low reset
//   w_en       : in  client write request, one entry per cycle
//   w_ovf_clr  : in  clears the sticky overflow flag
//   r_ptr_s    : in  Gray read pointer, already synchronized to clk_w
//   w_ptr      : out registered Gray write pointer, to read-side synchronizer
//   waddr      : out RAM write address
//   wr_mem     : out RAM write strobe (w_en & ~w_full)
//   w_full     : out registered full flag
//   w_ovf      : out sticky overflow, write attempted while full
//   w_level    : out occupancy seen from the write side
//   w_afull    : out w_level >= AFULL_THRESH
// -----------------------------------------------------------------------------
module fifo_wr_ctrl import async_fifo_pkg::*; #(
   parameter int POINTER_WIDTH = DEF_POINTER_WIDTH,
   parameter int AFULL_THRESH  = 14
) (
   input  logic                     clk_w,
   input  logic                     rst_n,
   input  logic                     w_en,
   input  logic                     w_ovf_clr,
   input  logic [POINTER_WIDTH:0]   r_ptr_s,
   output logic [POINTER_WIDTH:0]   w_ptr,
   output logic [POINTER_WIDTH-1:0] waddr,
   output logic                     wr_mem,
   output logic                     w_full,
   output logic                     w_ovf,
   output logic [POINTER_WIDTH:0]   w_level,
   output logic                     w_afull
);

   localparam int PW = POINTER_WIDTH;

   logic [PW:0] wbin_q, wbin_d;
   logic [PW:0] wgray_q, wgray_d;
   logic        w_full_q, w_full_d;
   logic        w_ovf_q, w_ovf_d;
   logic        accept;
   logic [PW:0] full_match;

   // A full FIFO has the write pointer exactly one lap ahead of the read
   // pointer; in Gray code that is the read pointer with its two MSBs inverted.
   assign full_match = {~r_ptr_s[PW:PW-1], r_ptr_s[PW-2:0]};

   always_comb begin
      accept   = w_en & ~w_full_q;
      wbin_d   = wbin_q + {{PW{1'b0}}, accept};
      wgray_d  = wbin_d ^ (wbin_d >> 1);
      w_full_d = (wgray_d == full_match);
      // Set has priority over clear so a collision never loses an overflow.
      w_ovf_d  = w_ovf_q;
      if (w_ovf_clr) begin
         w_ovf_d = 1'b0;
      end
      if (w_en & w_full_q) begin
         w_ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk_w or negedge rst_n) begin
      if (!rst_n) begin
         wbin_q   <= '0;
         wgray_q  <= '0;
         w_full_q <= 1'b0;
         w_ovf_q  <= 1'b0;
      end else begin
         wbin_q   <= wbin_d;
         wgray_q  <= wgray_d;
         w_full_q <= w_full_d;
         w_ovf_q  <= w_ovf_d;
      end
   end

   assign w_ptr  = wgray_q;
   assign waddr  = wbin_q[PW-1:0];
   assign wr_mem = accept;
   assign w_full = w_full_q;
   assign w_ovf  = w_ovf_q;

`ifdef WR_LEVEL_EN
   logic [PW:0] rbin;
   logic [PW:0] w_level_q, w_level_d;
   logic        w_afull_q, w_afull_d;

   gray_to_bin #(
      .W (PW + 1)
   ) u_gray_to_bin (
      .gray (r_ptr_s),
      .bin  (rbin)
   );

   // Modulo subtraction gives the occupancy directly, including the lap bit.
   always_comb begin
      w_level_d = wbin_d - rbin;
      w_afull_d = (int'(w_level_d) >= AFULL_THRESH);
   end

   always_ff @(posedge clk_w or negedge rst_n) begin
      if (!rst_n) begin
         w_level_q <= '0;
         w_afull_q <= 1'b0;
      end else begin
         w_level_q <= w_level_d;
         w_afull_q <= w_afull_d;
      end
   end

   assign w_level = w_level_q;
   assign w_afull = w_afull_q;
`else
   assign w_level = '0;
   assign w_afull = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
module tb_fifo_wr_ctrl;

   localparam int PW = 4;
   localparam int AF = 14;
   localparam int DEPTH = 16;
   localparam int LAP = 32;

   logic          clk_w = 1'b0;
   logic          rst_n = 1'b0;
   logic          w_en = 1'b0;
   logic          w_ovf_clr = 1'b0;
   logic [PW:0]   r_ptr_s = '0;
   logic [PW:0]   w_ptr;
   logic [PW-1:0] waddr;
   logic          wr_mem;
   logic          w_full;
   logic          w_ovf;
   logic [PW:0]   w_level;
   logic          w_afull;

   fifo_wr_ctrl #(
      .POINTER_WIDTH (PW),
      .AFULL_THRESH  (AF)
   ) dut (
      .clk_w     (clk_w),
      .rst_n     (rst_n),
      .w_en      (w_en),
      .w_ovf_clr (w_ovf_clr),
      .r_ptr_s   (r_ptr_s),
      .w_ptr     (w_ptr),
      .waddr     (waddr),
      .wr_mem    (wr_mem),
      .w_full    (w_full),
      .w_ovf     (w_ovf),
      .w_level   (w_level),
      .w_afull   (w_afull)
   );

   always #5 clk_w = ~clk_w;

   int total = 0;
   int bad   = 0;

   // Reference state: counts of entries written and read, kept as plain
   // integers modulo one lap; occupancy is their difference.
   int m_wcnt;
   int m_rcnt;
   bit m_full;
   bit m_ovf;
   int m_level;
   bit m_afull;

   function automatic logic [PW:0] gray(input int v);
      logic [PW:0] b;
      b = v[PW:0];
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_wcnt  = 0;
      m_rcnt  = 0;
      m_full  = 1'b0;
      m_ovf   = 1'b0;
      m_level = 0;
      m_afull = 1'b0;
   endtask

   task automatic check_outputs_reset(input string tag);
      chk({tag, "_w_ptr"}, w_ptr, 0);
      chk({tag, "_waddr"}, waddr, 0);
      chk({tag, "_w_full"}, w_full, 0);
      chk({tag, "_w_ovf"}, w_ovf, 0);
      chk({tag, "_w_level"}, w_level, 0);
      chk({tag, "_w_afull"}, w_afull, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      w_en = 1'b0;
      w_ovf_clr = 1'b0;
      r_ptr_s = '0;
      @(posedge clk_w);
      #1;
      check_outputs_reset("rst");
      rst_n = 1'b1;
      model_reset();
   endtask

   // One clock: drive inputs, check combinational outputs mid-cycle, then
   // check registered outputs just after the edge against the model.
   task automatic cycle(input bit w, input bit clr, input int rcnt);
      bit          acc;
      int          occ;
      logic [PW:0] prev;
      w_en      = w;
      w_ovf_clr = clr;
      m_rcnt    = rcnt % LAP;
      r_ptr_s   = gray(m_rcnt);
      @(negedge clk_w);
      acc = w && !m_full;
      chk("wr_mem", wr_mem, acc);
      chk("waddr", waddr, m_wcnt % DEPTH);
      prev = w_ptr;
      @(posedge clk_w);
      #1;
      if (w && m_full) m_ovf = 1'b1;
      else if (clr)    m_ovf = 1'b0;
      if (acc) m_wcnt = (m_wcnt + 1) % LAP;
      occ    = (m_wcnt - m_rcnt + LAP) % LAP;
      m_full = (occ == DEPTH);
`ifdef WR_LEVEL_EN
      m_level = occ;
      m_afull = (occ >= AF);
`else
      m_level = 0;
      m_afull = 1'b0;
`endif
      chk("w_ptr", w_ptr, gray(m_wcnt));
      chk("w_full", w_full, m_full);
      chk("w_ovf", w_ovf, m_ovf);
      chk("w_level", w_level, m_level);
      chk("w_afull", w_afull, m_afull);
      chk("gray_step", $countones(w_ptr ^ prev), acc);
   endtask

   initial begin
      model_reset();
      // Reset with idle inputs
      repeat (2) @(posedge clk_w);
      #1;
      check_outputs_reset("init");
      rst_n = 1'b1;

      // Fill: 16 writes with the read side idle
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b1, 1'b0, 0);
      end
      chk("fill_w_ptr", w_ptr, 5'b11000);
      chk("fill_w_full", w_full, 1);

      // Write while full is rejected and flagged
      cycle(1'b1, 1'b0, 0);
      chk("ovf_w_ptr", w_ptr, 5'b11000);
      chk("ovf_set", w_ovf, 1);
      // Set wins over a simultaneous clear
      cycle(1'b1, 1'b1, 0);
      chk("ovf_set_wins", w_ovf, 1);
      cycle(1'b0, 1'b1, 0);
      chk("ovf_clr", w_ovf, 0);

      // One read becomes visible: full drops, next write refills
      cycle(1'b0, 1'b0, 1);
      chk("read_unfull", w_full, 0);
      cycle(1'b1, 1'b0, 1);
      chk("refill_w_ptr", w_ptr, 5'b11001);
      chk("refill_full", w_full, 1);

      // Wrap: a full lap of writes with reads trailing one behind
      do_reset();
      for (int i = 0; i < LAP; i++) begin
         cycle(1'b1, 1'b0, m_wcnt);
      end
      cycle(1'b0, 1'b0, m_wcnt);
      chk("wrap_w_ptr", w_ptr, 5'b00000);
      chk("wrap_full", w_full, 0);

      // Level and almost-full
      do_reset();
      for (int i = 0; i < AF; i++) begin
         cycle(1'b1, 1'b0, 0);
      end
`ifdef WR_LEVEL_EN
      chk("level14", w_level, 14);
      chk("afull14", w_afull, 1);
`else
      chk("level14_off", w_level, 0);
      chk("afull14_off", w_afull, 0);
`endif
      cycle(1'b0, 1'b0, 3);
`ifdef WR_LEVEL_EN
      chk("level11", w_level, 11);
      chk("afull11", w_afull, 0);
`else
      chk("level11_off", w_level, 0);
      chk("afull11_off", w_afull, 0);
`endif

      // Randomized traffic: slow reader first (reaches full), then faster
      do_reset();
      for (int i = 0; i < 600; i++) begin
         int occ;
         int rd;
         bit w;
         bit clr;
         w   = ($urandom % 4) != 0;
         clr = ($urandom % 8) == 0;
         occ = (m_wcnt - m_rcnt + LAP) % LAP;
         rd  = m_rcnt;
         if (occ > 0 && ($urandom % 8) < ((i < 300) ? 2 : 6)) rd = m_rcnt + 1;
         cycle(w, clr, rd);
      end

      // Asynchronous reset in the middle of traffic
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0, m_rcnt);
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs_reset("async");
      @(posedge clk_w);
      #1;
      rst_n = 1'b1;
      model_reset();
      cycle(1'b1, 1'b0, 0);
      cycle(1'b1, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard time limit so the run can never hang
   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
